alu_16bit_sliced: RTL and testbench
===================================

Name: alu_16bit_sliced

Overview:
- 16-bit bit-sliced ALU with 74181-equivalent function set: 16 arithmetic and 16 logic operations, selected by a 4-bit select `s` and a mode bit `m`.
- Built from four 4-bit slices joined by carry-lookahead. Result and carry-out are registered.
- Serves as the datapath ALU feeding the register file and flag logic.

Parameters:
- none; width fixed at 16 (four 4-bit slices).

Ports:
- clk   input   1   system clock; all state updates on rising edge
- rst_n input   1   reset, synchronous, active-low
- a     input   16  operand A
- b     input   16  operand B
- cin   input   1   carry in, active-high (1 = add one); ignored when m=1
- m     input   1   mode: 0 = arithmetic, 1 = logic
- s     input   4   function select
- f     output  16  registered result
- cout  output  1   registered carry out of bit 15

Behaviour:
- Single clock. Synchronous active-low reset: on a rising clk edge with rst_n=0, f=16'h0000 and cout=0. Reset overrides any operation in flight.
- Latency is 1 cycle. Inputs sampled at edge N appear on f/cout after edge N. There is no handshake and a new operation is accepted every cycle.
- Arithmetic mode (m=0). Per bit, form:
  - E = A | (B&s0) | (~B&s1)
  - D = (A&~B&s2) | (A&B&s3)
  - Result is {cout,f} = E + D + cin, a 17-bit sum with wrap-around modulo 2^16.
- Resulting arithmetic table:
  - 0000 A
  - 0001 A|B
  - 0010 A|~B
  - 0011 all-ones (minus 1)
  - 0100 A+(A&~B)
  - 0101 (A|B)+(A&~B)
  - 0110 A-B-1
  - 0111 (A&~B)-1
  - 1000 A+(A&B)
  - 1001 A+B
  - 1010 (A|~B)+(A&B)
  - 1011 (A&B)-1
  - 1100 A+A
  - 1101 (A|B)+A
  - 1110 (A|~B)+A
  - 1111 A-1
  - Each entry then has cin added.
- Logic mode (m=1), bitwise, cin ignored, cout=0:
  - 0000 ~A
  - 0001 ~(A|B)
  - 0010 ~A&B
  - 0011 0
  - 0100 ~(A&B)
  - 0101 ~B
  - 0110 A^B
  - 0111 A&~B
  - 1000 ~A|B
  - 1001 ~(A^B)
  - 1010 B
  - 1011 A&B
  - 1100 all-ones
  - 1101 A|~B
  - 1110 A|B
  - 1111 A
- Carry structure:
  - Each slice produces group propagate P = &E_i-derived propagate terms and group generate G.
  - Slice carries c4, c8, c12 and cout come from a one-level lookahead: c(k+1) = G_k | P_k&c_k, with c0 = cin.
  - No ripple between slices.
- Boundary cases:
  - 0xFFFF + 1 gives f=0, cout=1.
  - s=0011, m=0, cin=1 gives f=0, cout=1.
  - X inputs are not required to be handled.

Decomposition:
- Shared package alu_pkg holds the m encodings (ALU_ARITH=0, ALU_LOGIC=1) and named 4-bit constants for all 16 s codes, e.g. S_ADD=4'b1001, S_SUB_M1=4'b0110.
- Sub-module alu_4bit_slice is instantiated 4 times. It is purely combinational. Inputs: a[3:0], b[3:0], cin, m, s. Outputs: f[3:0], group P, group G.
- The top level contains the lookahead carry logic and the output registers.

Test Plan:
- Reset: rst_n=0 for 2 cycles with any inputs -> f=0x0000, cout=0. Release rst_n=1 with a=2, b=1, s=0000, m=0, cin=0 -> next cycle f=0x0002, cout=0.
- m=0 arithmetic sweep, each result one cycle after apply:
  - s=0001, a=2, b=5, cin=1 -> f=0x0008, cout=0
  - s=0010, a=2, b=3, cin=1 -> f=0xFFFF, cout=0
  - s=0011, cin=0 -> f=0xFFFF, cout=0
  - s=0100, a=2, b=5, cin=1 -> f=0x0005, cout=0
- Add/subtract wrap:
  - s=1001, a=0xFFFF, b=1, cin=0 -> f=0x0000, cout=1
  - s=0110, a=5, b=3, cin=1 -> f=0x0002, cout=1
  - s=0110, a=3, b=5, cin=1 -> f=0xFFFE, cout=0
- m=1 logic:
  - s=0000, a=2 -> f=0xFFFD, cout=0
  - s=0100, a=2, b=5 -> f=0xFFFF
  - s=0110, a=0x00FF, b=0x0F0F -> f=0x0FF0
  - cin=1 has no effect in any logic case
- Lookahead stress: s=1001, a=0x0FFF, b=0x0001, cin=0 -> f=0x1000; a=0x7FFF, b=0, cin=1 -> f=0x8000, cout=0.
- Back-to-back pipeline: change inputs every cycle across 8 random ops and check each result lands exactly 1 cycle later. Assert rst_n=0 mid-stream -> outputs 0 on the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the sliced ALU: mode bit and the sixteen function selects.
// Select names follow the arithmetic-mode meaning (before cin is added).
package alu_pkg;

  localparam logic ALU_ARITH = 1'b0;
  localparam logic ALU_LOGIC = 1'b1;

  localparam logic [3:0] S_A              = 4'b0000;
  localparam logic [3:0] S_A_OR_B         = 4'b0001;
  localparam logic [3:0] S_A_OR_NB        = 4'b0010;
  localparam logic [3:0] S_MINUS1         = 4'b0011;
  localparam logic [3:0] S_A_PLUS_ANB     = 4'b0100;
  localparam logic [3:0] S_AORB_PLUS_ANB  = 4'b0101;
  localparam logic [3:0] S_SUB_M1         = 4'b0110;
  localparam logic [3:0] S_ANB_M1         = 4'b0111;
  localparam logic [3:0] S_A_PLUS_AB      = 4'b1000;
  localparam logic [3:0] S_ADD            = 4'b1001;
  localparam logic [3:0] S_AORNB_PLUS_AB  = 4'b1010;
  localparam logic [3:0] S_AB_M1          = 4'b1011;
  localparam logic [3:0] S_DOUBLE         = 4'b1100;
  localparam logic [3:0] S_AORB_PLUS_A    = 4'b1101;
  localparam logic [3:0] S_AORNB_PLUS_A   = 4'b1110;
  localparam logic [3:0] S_DEC            = 4'b1111;

endpackage

// File: rtl/alu_4bit_slice.sv
// One 4-bit 74181-style slice: combinational result plus group propagate/generate.
// Latency 0; no flow control.
module alu_4bit_slice
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       m,
  input  logic [3:0] s,
  output logic [3:0] f,
  output logic       p,
  output logic       g
);

  logic [3:0] e;
  logic [3:0] d;
  logic [3:0] c;

  // d can only be set where a is set, so d implies e: e is the propagate and d the generate.
  always_comb begin
    e = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    d = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});

    c[0] = cin;
    c[1] = d[0] | (e[0] & cin);
    c[2] = d[1] | (e[1] & d[0]) | (e[1] & e[0] & cin);
    c[3] = d[2] | (e[2] & d[1]) | (e[2] & e[1] & d[0]) | (e[2] & e[1] & e[0] & cin);

    p = &e;
    g = d[3] | (e[3] & d[2]) | (e[3] & e[2] & d[1]) | (e[3] & e[2] & e[1] & d[0]);

    // With carries suppressed, ~(e^d) yields exactly the logic-mode function table.
    if (m == ALU_LOGIC) begin
      f = ~(e ^ d);
    end else begin
      f = e ^ d ^ c;
    end
  end

endmodule

// File: rtl/alu_16bit_sliced.sv
// 16-bit ALU from four slices joined by single-level carry lookahead; f/cout registered.
// Latency 1 cycle; accepts a new operation every cycle, no backpressure.
module alu_16bit_sliced
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic        m,
  input  logic [3:0]  s,
  output logic [15:0] f,
  output logic        cout
);

  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [3:0]  slc_cin;
  logic        c16;
  logic [15:0] f_nxt;

  // Every slice carry is a flat sum of products of group terms and cin.
  always_comb begin
    slc_cin[0] = cin;
    slc_cin[1] = gg[0] | (gp[0] & cin);
    slc_cin[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    slc_cin[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
    c16        = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
  end

  for (genvar i = 0; i < 4; i++) begin : g_slice
    alu_4bit_slice u_slice (
      .a   (a[4*i +: 4]),
      .b   (b[4*i +: 4]),
      .cin (slc_cin[i]),
      .m   (m),
      .s   (s),
      .f   (f_nxt[4*i +: 4]),
      .p   (gp[i]),
      .g   (gg[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f    <= 16'h0000;
      cout <= 1'b0;
    end else begin
      f    <= f_nxt;
      cout <= (m == ALU_ARITH) & c16;
    end
  end

endmodule

// File: tb/tb_alu_16bit_sliced.sv
// Bench for alu_16bit_sliced: directed table cases plus random back-to-back ops
// checked against a function-table reference model.
module tb_alu_16bit_sliced;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b, f;
  logic        cin, m, cout;
  logic [3:0]  s;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [16:0] prev_exp;

  alu_16bit_sliced dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .m    (m),
    .s    (s),
    .f    (f),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got {cout,f}=%h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the function tables as plain 17-bit arithmetic ("-1" is adding 16'hFFFF).
  function automatic logic [16:0] ref_alu(input logic [15:0] ra, input logic [15:0] rb,
                                          input logic rc, input logic rm, input logic [3:0] rs);
    logic [15:0] x, y, r;
    x = 16'h0; y = 16'h0; r = 16'h0;
    if (rm) begin
      case (rs)
        4'h0: r = ~ra;          4'h1: r = ~(ra | rb);
        4'h2: r = ~ra & rb;     4'h3: r = 16'h0000;
        4'h4: r = ~(ra & rb);   4'h5: r = ~rb;
        4'h6: r = ra ^ rb;      4'h7: r = ra & ~rb;
        4'h8: r = ~ra | rb;     4'h9: r = ~(ra ^ rb);
        4'hA: r = rb;           4'hB: r = ra & rb;
        4'hC: r = 16'hFFFF;     4'hD: r = ra | ~rb;
        4'hE: r = ra | rb;      default: r = ra;
      endcase
      return {1'b0, r};
    end
    case (rs)
      4'h0: begin x = ra;            y = 16'h0;     end
      4'h1: begin x = ra | rb;       y = 16'h0;     end
      4'h2: begin x = ra | ~rb;      y = 16'h0;     end
      4'h3: begin x = 16'hFFFF;      y = 16'h0;     end
      4'h4: begin x = ra;            y = ra & ~rb;  end
      4'h5: begin x = ra | rb;       y = ra & ~rb;  end
      4'h6: begin x = ra;            y = ~rb;       end
      4'h7: begin x = ra & ~rb;      y = 16'hFFFF;  end
      4'h8: begin x = ra;            y = ra & rb;   end
      4'h9: begin x = ra;            y = rb;        end
      4'hA: begin x = ra | ~rb;      y = ra & rb;   end
      4'hB: begin x = ra & rb;       y = 16'hFFFF;  end
      4'hC: begin x = ra;            y = ra;        end
      4'hD: begin x = ra | rb;       y = ra;        end
      4'hE: begin x = ra | ~rb;      y = ra;        end
      default: begin x = ra;         y = 16'hFFFF;  end
    endcase
    return {1'b0, x} + {1'b0, y} + {16'h0, rc};
  endfunction

  task automatic apply(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                       input logic tm, input logic [3:0] ts);
    a = ta; b = tb; cin = tc; m = tm; s = ts;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Directed op: checked against the hand-derived value and against the model.
  task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                    input logic tc, input logic tm, input logic [3:0] ts, input logic [16:0] exp);
    apply(ta, tb, tc, tm, ts);
    step();
    chk(tag, {cout, f}, exp);
    chk({tag, "/model"}, {cout, f}, ref_alu(ta, tb, tc, tm, ts));
  endtask

  initial begin
    rst_n = 1'b0;
    apply(16'($urandom), 16'($urandom), 1'b1, ALU_ARITH, S_ADD);
    step();
    step();
    chk("reset", {cout, f}, 17'h00000);

    rst_n = 1'b1;
    op("release",    16'h0002, 16'h0001, 1'b0, ALU_ARITH, S_A,         17'h00002);
    op("a_or_b+1",   16'h0002, 16'h0005, 1'b1, ALU_ARITH, S_A_OR_B,    17'h00008);
    op("a_or_nb+1",  16'h0002, 16'h0003, 1'b1, ALU_ARITH, S_A_OR_NB,   17'h0FFFF);
    op("minus1",     16'h1234, 16'h5678, 1'b0, ALU_ARITH, S_MINUS1,    17'h0FFFF);
    op("a+anb+1",    16'h0002, 16'h0005, 1'b1, ALU_ARITH, S_A_PLUS_ANB, 17'h00005);
    op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, ALU_ARITH, S_ADD,       17'h10000);
    op("sub_pos",    16'h0005, 16'h0003, 1'b1, ALU_ARITH, S_SUB_M1,    17'h10002);
    op("sub_neg",    16'h0003, 16'h0005, 1'b1, ALU_ARITH, S_SUB_M1,    17'h0FFFE);
    op("minus1_c1",  16'hABCD, 16'h0F0F, 1'b1, ALU_ARITH, S_MINUS1,    17'h10000);
    op("inc_wrap",   16'hFFFF, 16'h0000, 1'b1, ALU_ARITH, S_A,         17'h10000);
    op("not_a",      16'h0002, 16'h0000, 1'b0, ALU_LOGIC, 4'b0000,     17'h0FFFD);
    op("nand",       16'h0002, 16'h0005, 1'b1, ALU_LOGIC, 4'b0100,     17'h0FFFF);
    op("xor",        16'h00FF, 16'h0F0F, 1'b1, ALU_LOGIC, 4'b0110,     17'h00FF0);
    op("la_c12",     16'h0FFF, 16'h0001, 1'b0, ALU_ARITH, S_ADD,       17'h01000);
    op("la_c16",     16'h7FFF, 16'h0000, 1'b1, ALU_ARITH, S_ADD,       17'h08000);

    // Every logic code with both cin values: cin must not disturb the result.
    for (int i = 0; i < 32; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      apply(ra, rb, i[0], ALU_LOGIC, i[4:1]);
      step();
      chk($sformatf("logic_s%0d_c%0d", i[4:1], i[0]), {cout, f}, ref_alu(ra, rb, i[0], ALU_LOGIC, i[4:1]));
    end

    // Random back-to-back stream: output must hold until the edge, then show the new op.
    prev_exp = {cout, f};
    for (int i = 0; i < 300; i++) begin
      logic [15:0] ra, rb;
      logic        rc, rm;
      logic [3:0]  rs;
      ra = (i % 5 == 0) ? 16'hFFFF : 16'($urandom);
      rb = (i % 7 == 0) ? 16'h0001 : 16'($urandom);
      rc = 1'($urandom);
      rm = 1'($urandom_range(0, 1));
      rs = 4'($urandom);
      apply(ra, rb, rc, rm, rs);
      chk($sformatf("hold_%0d", i), {cout, f}, prev_exp);
      step();
      prev_exp = ref_alu(ra, rb, rc, rm, rs);
      chk($sformatf("rand_%0d_m%0d_s%h", i, rm, rs), {cout, f}, prev_exp);
    end

    rst_n = 1'b0;
    apply(16'hFFFF, 16'h0001, 1'b1, ALU_ARITH, S_ADD);
    step();
    chk("mid_reset", {cout, f}, 17'h00000);
    rst_n = 1'b1;
    op("post_reset", 16'h1234, 16'h1111, 1'b0, ALU_ARITH, S_ADD, 17'h02345);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
